seizure_apb_regbank: RTL and testbench
======================================

SEIZURE_APB_REGBANK -- requirements
Module: seizure_apb_regbank

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, EEG channel count (1..16); SAMPLE_W, default 18, sample width; DEPTH, default 16, per-channel FIFO depth (power of 2, >=2); LUT_W, default 72, LUT word width (33..128); LUT_AW, default 11, LUT address width.
REQ-002 apb_clk  in  1  single clock; reset is synchronous and active-low.
REQ-003 reset_n  in  1  synchronous active-low reset, sampled on rising apb_clk.
REQ-004 apb_addr in 10, apb_psel in 1, apb_penable in 1, apb_pwrite in 1, apb_pwdata in 32  APB requester signals.
REQ-005 apb_prdata out 32, apb_ready out 1  APB completer response.
REQ-006 core_pop in 1, core_ch in $clog2(NUM_CH)  pop one sample from the FIFO of channel core_ch.
REQ-007 core_data out SAMPLE_W, core_valid out 1  popped sample and its qualifier.
REQ-008 core_busy in 1  core status, readable via STATUS.
REQ-009 start_core out 1, lut_wr_en out 1, lut_wr_addr out LUT_AW, lut_wr_data out LUT_W  control pulse and LUT write port.

Function
REQ-010 Register map (byte offsets): 0x000 CTRL, 0x004 STATUS, 0x008 CH_SEL, 0x00C SAMPLE, 0x010 LUT_ADDR, 0x014 LUT_COMMIT, 0x020+4k LUT_BEAT[k] for k=0..ceil(LUT_W/32)-1; any other offset is unmapped.
REQ-011 Every APB transfer SHALL complete with exactly one wait state: apb_ready high for one cycle, the cycle after the first cycle with apb_psel&&apb_penable; write side effects and apb_prdata take effect in that ready cycle.
REQ-012 CTRL write: bit0=1 SHALL produce a one-cycle start_core pulse; bit1=1 SHALL flush all FIFOs (counts and pointers to 0) and clear sticky flags; CTRL reads return 0.
REQ-013 STATUS read: bit0 core_busy, bit1 sticky overflow, bit2 sticky underflow, bits[16+c] FIFO c full; other bits 0.
REQ-014 CH_SEL holds $clog2(NUM_CH) bits (reset 0); a written value >= NUM_CH SHALL be ignored (old value kept).
REQ-015 SAMPLE write SHALL push apb_pwdata[SAMPLE_W-1:0] into FIFO CH_SEL; push to a full FIFO SHALL be dropped and set sticky overflow.
REQ-016 SAMPLE read SHALL return {count of FIFO CH_SEL, zero-padded} in bits[31:16] and the head sample zero-extended in bits[15:0] region only when SAMPLE_W<=16, else bits[31:0] = head sample zero-extended; reads SHALL NOT pop.
REQ-017 core_pop: core_data/core_valid SHALL update one cycle after core_pop; pop on empty gives core_valid=0, core_data=0, sets sticky underflow; core_valid is otherwise low.
REQ-018 Simultaneous push and pop on the same channel SHALL both occur; count unchanged; on a full FIFO both SHALL succeed (no overflow); on empty, pop underflows and push succeeds.
REQ-019 Pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-020 LUT_BEAT[k] write SHALL load staging bits [32k+31:32k] (top beat truncated to LUT_W); reads return staged value.
REQ-021 LUT_COMMIT write SHALL pulse lut_wr_en for one cycle, next cycle, with lut_wr_addr=LUT_ADDR and lut_wr_data=staging; LUT_ADDR then auto-increments, wrapping at 2^LUT_AW.
REQ-022 CTRL flush coincident with core_pop SHALL win: FIFOs empty, core_valid=0.

Reset
REQ-023 reset_n low SHALL clear all outputs to 0, all FIFOs, CH_SEL, LUT_ADDR, staging, sticky flags and any pending APB transfer; FIFO storage contents need not be cleared.

Configuration
REQ-024 SEIZURE_REGBANK_PSLVERR_EN defined: add output apb_pslverr (1), high with apb_ready for unmapped addresses and for writes to STATUS; no side effects. Undefined: port absent, unmapped reads return 0, writes ignored.

Verification
REQ-025 Reset, then CTRL write 0x1 -> start_core high exactly one cycle; all other outputs 0.
REQ-026 CH_SEL=2, SAMPLE writes 0x3FFFF,0x00001 -> core_pop ch2 twice yields 0x3FFFF then 0x00001, third pop core_valid=0 and STATUS bit2=1.
REQ-027 DEPTH=16: 17 SAMPLE writes to ch0 -> STATUS bit16=1, bit1=1, 16 pops return first 16 values in order.
REQ-028 Full ch0, same-cycle push and pop -> count stays 16, no overflow, pop returns oldest value.
REQ-029 LUT_ADDR=0x7FF, beats 0xAABBCCDD,0x11223344,0x55 then COMMIT -> lut_wr_data=0x55_11223344_AABBCCDD at 0x7FF, LUT_ADDR reads 0x000.
REQ-030 With SEIZURE_REGBANK_PSLVERR_EN, read 0x3FC -> apb_pslverr=1, apb_prdata=0; without it, apb_prdata=0 and no error port.

Source files
------------

// File: rtl/seizure_apb_regbank_if.sv
// -----------------------------------------------------------------------------
// seizure_apb_regbank_if
// APB bus bundle for the seizure-detector register bank.
//   master modport : requester side (drives addr/psel/penable/pwrite/pwdata)
//   slave  modport : completer side (drives prdata/ready[/pslverr])
// Optional macro SEIZURE_REGBANK_PSLVERR_EN adds the apb_pslverr response.
// -----------------------------------------------------------------------------
interface seizure_apb_regbank_if;
    logic [9:0]  apb_addr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_ready;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
    logic        apb_pslverr;

    modport master (
        output apb_addr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        input  apb_prdata, apb_ready, apb_pslverr
    );
    modport slave (
        input  apb_addr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        output apb_prdata, apb_ready, apb_pslverr
    );
`else
    modport master (
        output apb_addr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        input  apb_prdata, apb_ready
    );
    modport slave (
        input  apb_addr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        output apb_prdata, apb_ready
    );
`endif
endinterface

// File: rtl/seizure_apb_regbank.sv
// -----------------------------------------------------------------------------
// seizure_apb_regbank
// APB register bank for an EEG seizure-detection core: per-channel sample
// FIFOs written over APB and popped by the core, a start pulse, sticky
// overflow/underflow status and a staged wide-word LUT write port.
//
// Ports
//   apb_clk, reset_n        : single clock, synchronous active-low reset
//   apb (slave modport)     : APB completer; one wait state per transfer
//   core_pop, core_ch       : pop one sample from FIFO core_ch
//   core_data, core_valid   : popped sample, valid one cycle after core_pop
//   core_busy               : core status, reported in STATUS bit0
//   start_core              : one-cycle pulse from CTRL bit0
//   lut_wr_en/addr/data     : LUT write port driven by LUT_COMMIT
//
// Optional feature: define SEIZURE_REGBANK_PSLVERR_EN to add apb_pslverr,
// asserted with apb_ready for unmapped offsets and for writes to STATUS.
//
// Map: 0x000 CTRL, 0x004 STATUS, 0x008 CH_SEL, 0x00C SAMPLE, 0x010 LUT_ADDR,
//      0x014 LUT_COMMIT, 0x020+4k LUT_BEAT[k].
// -----------------------------------------------------------------------------
module seizure_apb_regbank #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 18,
    parameter int DEPTH    = 16,
    parameter int LUT_W    = 72,
    parameter int LUT_AW   = 11,
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 apb_clk,
    input  logic                 reset_n,
    seizure_apb_regbank_if.slave apb,
    input  logic                 core_pop,
    input  logic [CHW-1:0]       core_ch,
    output logic [SAMPLE_W-1:0]  core_data,
    output logic                 core_valid,
    input  logic                 core_busy,
    output logic                 start_core,
    output logic                 lut_wr_en,
    output logic [LUT_AW-1:0]    lut_wr_addr,
    output logic [LUT_W-1:0]     lut_wr_data
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NB   = (LUT_W + 31) / 32;
    localparam int BKW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PADW = 32 * (1 << BKW);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [9:0]    BEAT_END = 10'(32 + 4 * NB);

    // Registered state
    logic                 apb_ready_q, apb_ready_d;
    logic [31:0]          apb_prdata_q, apb_prdata_d;
    logic                 start_core_q, start_core_d;
    logic                 lut_pend_q, lut_pend_d;
    logic                 lut_wr_en_q, lut_wr_en_d;
    logic [LUT_AW-1:0]    lut_wr_addr_q, lut_wr_addr_d;
    logic [LUT_W-1:0]     lut_wr_data_q, lut_wr_data_d;
    logic                 core_valid_q, core_valid_d;
    logic [SAMPLE_W-1:0]  core_data_q, core_data_d;
    logic [CHW-1:0]       ch_sel_q, ch_sel_d;
    logic [LUT_AW-1:0]    lut_addr_q, lut_addr_d;
    logic [LUT_W-1:0]     stage_q, stage_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic [PW-1:0]        wr_ptr_q [NUM_CH];
    logic [PW-1:0]        wr_ptr_d [NUM_CH];
    logic [PW-1:0]        rd_ptr_q [NUM_CH];
    logic [PW-1:0]        rd_ptr_d [NUM_CH];
    logic [CW-1:0]        cnt_q    [NUM_CH];
    logic [CW-1:0]        cnt_d    [NUM_CH];
`ifdef SEIZURE_REGBANK_PSLVERR_EN
    logic                 apb_pslverr_q, apb_pslverr_d;
`endif

    // FIFO storage; contents are don't-care after reset, so no reset term
    logic [SAMPLE_W-1:0]  fifo_mem [NUM_CH][DEPTH];

    // Combinational helpers
    logic                 acc_s, err_s, wr_s, rd_s, mapped_s;
    logic                 sel_ctrl_s, sel_status_s, sel_chsel_s, sel_sample_s;
    logic                 sel_lutaddr_s, sel_commit_s, sel_beat_s;
    logic [BKW-1:0]       beat_idx_s;
    logic [31:0]          rdata_s, status_s, sample_rd_s;
    logic [SAMPLE_W-1:0]  head_s, pop_data_s;
    logic [PADW-1:0]      stage_pad_s, stage_pad_w_s;
    logic                 flush_s, push_req_s, push_any_s, pop_hit_s;
    logic                 ovf_set_s, udf_set_s, pop_ok_s;
    logic                 push_go_s [NUM_CH];
    logic                 pop_go_s  [NUM_CH];

    assign apb.apb_ready  = apb_ready_q;
    assign apb.apb_prdata = apb_prdata_q;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
    assign apb.apb_pslverr = apb_pslverr_q;
`endif
    assign start_core  = start_core_q;
    assign lut_wr_en   = lut_wr_en_q;
    assign lut_wr_addr = lut_wr_addr_q;
    assign lut_wr_data = lut_wr_data_q;
    assign core_valid  = core_valid_q;
    assign core_data   = core_data_q;

    // Access-phase detect and address decode; ready_q masks the completing cycle
    always_comb begin
        acc_s         = apb.apb_psel && apb.apb_penable && !apb_ready_q;
        beat_idx_s    = BKW'((apb.apb_addr - 10'h020) >> 2);
        sel_ctrl_s    = (apb.apb_addr == 10'h000);
        sel_status_s  = (apb.apb_addr == 10'h004);
        sel_chsel_s   = (apb.apb_addr == 10'h008);
        sel_sample_s  = (apb.apb_addr == 10'h00C);
        sel_lutaddr_s = (apb.apb_addr == 10'h010);
        sel_commit_s  = (apb.apb_addr == 10'h014);
        sel_beat_s    = (apb.apb_addr >= 10'h020) && (apb.apb_addr < BEAT_END) &&
                        (apb.apb_addr[1:0] == 2'b00);
        mapped_s      = sel_ctrl_s | sel_status_s | sel_chsel_s | sel_sample_s |
                        sel_lutaddr_s | sel_commit_s | sel_beat_s;
        // STATUS is read-only; a write to it is treated like an unmapped access
        err_s         = !mapped_s || (sel_status_s && apb.apb_pwrite);
        wr_s          = acc_s && apb.apb_pwrite && !err_s;
        rd_s          = acc_s && !apb.apb_pwrite && !err_s;
    end

    // Read-data multiplexer (reads never alter state)
    always_comb begin
        status_s    = 32'h0000_0000;
        status_s[0] = core_busy;
        status_s[1] = ovf_q;
        status_s[2] = udf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            status_s[16 + c] = (cnt_q[c] == CNT_FULL);
        end
        head_s = (cnt_q[ch_sel_q] != {CW{1'b0}}) ? fifo_mem[ch_sel_q][rd_ptr_q[ch_sel_q]]
                                                  : {SAMPLE_W{1'b0}};
        if (SAMPLE_W <= 16) begin
            sample_rd_s = {16'(cnt_q[ch_sel_q]), 16'(head_s)};
        end else begin
            sample_rd_s = 32'(head_s);
        end
        stage_pad_s = PADW'(stage_q);
        if (sel_status_s) begin
            rdata_s = status_s;
        end else if (sel_chsel_s) begin
            rdata_s = 32'(ch_sel_q);
        end else if (sel_sample_s) begin
            rdata_s = sample_rd_s;
        end else if (sel_lutaddr_s) begin
            rdata_s = 32'(lut_addr_q);
        end else if (sel_beat_s) begin
            rdata_s = stage_pad_s[{beat_idx_s, 5'b00000} +: 32];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // FIFO next state: per-channel push/pop arbitration, flush overrides all
    always_comb begin
        flush_s    = wr_s && sel_ctrl_s && apb.apb_pwdata[1];
        push_req_s = wr_s && sel_sample_s;
        push_any_s = 1'b0;
        pop_hit_s  = 1'b0;
        pop_ok_s   = 1'b0;
        ovf_set_s  = 1'b0;
        udf_set_s  = 1'b0;
        pop_data_s = {SAMPLE_W{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            pop_go_s[c]  = core_pop && (core_ch == CHW'(c)) && (cnt_q[c] != {CW{1'b0}});
            // A same-cycle pop frees the slot, so a full FIFO still accepts the push
            push_go_s[c] = push_req_s && (ch_sel_q == CHW'(c)) &&
                           ((cnt_q[c] != CNT_FULL) || pop_go_s[c]);
            pop_hit_s    = pop_hit_s | (core_pop && (core_ch == CHW'(c)));
            pop_ok_s     = pop_ok_s | pop_go_s[c];
            push_any_s   = push_any_s | push_go_s[c];
            pop_data_s   = pop_data_s | (pop_go_s[c] ? fifo_mem[c][rd_ptr_q[c]]
                                                     : {SAMPLE_W{1'b0}});
            wr_ptr_d[c]  = push_go_s[c] ? (wr_ptr_q[c] + PTR_ONE) : wr_ptr_q[c];
            rd_ptr_d[c]  = pop_go_s[c] ? (rd_ptr_q[c] + PTR_ONE) : rd_ptr_q[c];
            if (push_go_s[c] && !pop_go_s[c]) begin
                cnt_d[c] = cnt_q[c] + CNT_ONE;
            end else if (!push_go_s[c] && pop_go_s[c]) begin
                cnt_d[c] = cnt_q[c] - CNT_ONE;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
        ovf_set_s = push_req_s && !push_any_s;
        udf_set_s = core_pop && !pop_ok_s;
        if (flush_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_d[c] = {PW{1'b0}};
                rd_ptr_d[c] = {PW{1'b0}};
                cnt_d[c]    = {CW{1'b0}};
            end
            ovf_d        = 1'b0;
            udf_d        = 1'b0;
            core_valid_d = 1'b0;
            core_data_d  = {SAMPLE_W{1'b0}};
        end else begin
            ovf_d        = ovf_q | ovf_set_s;
            udf_d        = udf_q | udf_set_s;
            core_valid_d = pop_ok_s;
            core_data_d  = pop_data_s;
        end
    end

    // Register, LUT and APB response next state
    always_comb begin
        apb_ready_d   = acc_s;
        apb_prdata_d  = rd_s ? rdata_s : 32'h0000_0000;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
        apb_pslverr_d = acc_s && err_s;
`endif
        start_core_d  = wr_s && sel_ctrl_s && apb.apb_pwdata[0];
        if (wr_s && sel_chsel_s && (apb.apb_pwdata < 32'(NUM_CH))) begin
            ch_sel_d = apb.apb_pwdata[CHW-1:0];
        end else begin
            ch_sel_d = ch_sel_q;
        end
        stage_pad_w_s = PADW'(stage_q);
        stage_pad_w_s[{beat_idx_s, 5'b00000} +: 32] = apb.apb_pwdata;
        if (wr_s && sel_beat_s) begin
            stage_d = stage_pad_w_s[LUT_W-1:0];
        end else begin
            stage_d = stage_q;
        end
        // Commit captures address/data now; the write strobe follows a cycle later
        lut_pend_d  = wr_s && sel_commit_s;
        lut_wr_en_d = lut_pend_q;
        if (wr_s && sel_commit_s) begin
            lut_wr_addr_d = lut_addr_q;
            lut_wr_data_d = stage_q;
            lut_addr_d    = lut_addr_q + LUT_AW'(1);
        end else if (wr_s && sel_lutaddr_s) begin
            lut_wr_addr_d = lut_wr_addr_q;
            lut_wr_data_d = lut_wr_data_q;
            lut_addr_d    = apb.apb_pwdata[LUT_AW-1:0];
        end else begin
            lut_wr_addr_d = lut_wr_addr_q;
            lut_wr_data_d = lut_wr_data_q;
            lut_addr_d    = lut_addr_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge apb_clk) begin
        if (!reset_n) begin
            apb_ready_q   <= 1'b0;
            apb_prdata_q  <= 32'h0000_0000;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
            apb_pslverr_q <= 1'b0;
`endif
            start_core_q  <= 1'b0;
            lut_pend_q    <= 1'b0;
            lut_wr_en_q   <= 1'b0;
            lut_wr_addr_q <= {LUT_AW{1'b0}};
            lut_wr_data_q <= {LUT_W{1'b0}};
            core_valid_q  <= 1'b0;
            core_data_q   <= {SAMPLE_W{1'b0}};
            ch_sel_q      <= {CHW{1'b0}};
            lut_addr_q    <= {LUT_AW{1'b0}};
            stage_q       <= {LUT_W{1'b0}};
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= {PW{1'b0}};
                rd_ptr_q[c] <= {PW{1'b0}};
                cnt_q[c]    <= {CW{1'b0}};
            end
        end else begin
            apb_ready_q   <= apb_ready_d;
            apb_prdata_q  <= apb_prdata_d;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
            apb_pslverr_q <= apb_pslverr_d;
`endif
            start_core_q  <= start_core_d;
            lut_pend_q    <= lut_pend_d;
            lut_wr_en_q   <= lut_wr_en_d;
            lut_wr_addr_q <= lut_wr_addr_d;
            lut_wr_data_q <= lut_wr_data_d;
            core_valid_q  <= core_valid_d;
            core_data_q   <= core_data_d;
            ch_sel_q      <= ch_sel_d;
            lut_addr_q    <= lut_addr_d;
            stage_q       <= stage_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    // FIFO storage write; push_any_s already excludes flush and dropped pushes
    always_ff @(posedge apb_clk) begin
        if (reset_n && push_any_s) begin
            fifo_mem[ch_sel_q][wr_ptr_q[ch_sel_q]] <= apb.apb_pwdata[SAMPLE_W-1:0];
        end else begin
            fifo_mem[ch_sel_q][wr_ptr_q[ch_sel_q]] <= fifo_mem[ch_sel_q][wr_ptr_q[ch_sel_q]];
        end
    end

endmodule

// File: tb/tb_seizure_apb_regbank.sv
// -----------------------------------------------------------------------------
// tb_seizure_apb_regbank
// Self-checking bench: directed scenarios followed by random APB/pop traffic,
// all checked against a queue-based reference model of the register bank.
// -----------------------------------------------------------------------------
module tb_seizure_apb_regbank;
    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 18;
    localparam int DEPTH    = 16;
    localparam int LUT_W    = 72;
    localparam int LUT_AW   = 11;

    localparam logic [9:0] A_CTRL = 10'h000, A_STATUS = 10'h004, A_CHSEL = 10'h008;
    localparam logic [9:0] A_SAMPLE = 10'h00C, A_LADDR = 10'h010, A_COMMIT = 10'h014;
    localparam logic [9:0] A_BEAT0 = 10'h020;

    logic                 apb_clk = 1'b0;
    logic                 reset_n;
    logic                 core_pop;
    logic [1:0]           core_ch;
    logic [SAMPLE_W-1:0]  core_data;
    logic                 core_valid;
    logic                 core_busy;
    logic                 start_core;
    logic                 lut_wr_en;
    logic [LUT_AW-1:0]    lut_wr_addr;
    logic [LUT_W-1:0]     lut_wr_data;

    seizure_apb_regbank_if apb_bus();

    seizure_apb_regbank #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH),
        .LUT_W(LUT_W), .LUT_AW(LUT_AW)
    ) dut (
        .apb_clk     (apb_clk),
        .reset_n     (reset_n),
        .apb         (apb_bus),
        .core_pop    (core_pop),
        .core_ch     (core_ch),
        .core_data   (core_data),
        .core_valid  (core_valid),
        .core_busy   (core_busy),
        .start_core  (start_core),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data)
    );

    always #5 apb_clk = ~apb_clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [SAMPLE_W-1:0] fq [NUM_CH][$];
    logic        m_ovf, m_udf;
    int          m_ch;
    logic [10:0] m_laddr;
    logic [95:0] m_stage;
    logic        last_err;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_push(input int ch, input logic [SAMPLE_W-1:0] v);
        if (fq[ch].size() < DEPTH) fq[ch].push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic m_pop(input int ch, output logic ev, output logic [SAMPLE_W-1:0] ed);
        if (fq[ch].size() > 0) begin
            ev = 1'b1;
            ed = fq[ch].pop_front();
        end else begin
            ev = 1'b0;
            ed = '0;
            m_udf = 1'b1;
        end
    endtask

    task automatic m_flush();
        for (int c = 0; c < NUM_CH; c++) fq[c].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[0] = core_busy;
        s[1] = m_ovf;
        s[2] = m_udf;
        for (int c = 0; c < NUM_CH; c++) s[16 + c] = (fq[c].size() == DEPTH);
        return s;
    endfunction

    // One APB transfer; optionally raises core_pop for the access-phase edge.
    task automatic apb_xfer(input logic [9:0] a, input logic w, input logic [31:0] d,
                            input logic do_pop, input logic [1:0] pch,
                            output logic [31:0] r, output logic pv,
                            output logic [SAMPLE_W-1:0] pd, output logic sc);
        int waits;
        logic got;
        @(posedge apb_clk); #1;
        apb_bus.apb_addr = a; apb_bus.apb_pwrite = w; apb_bus.apb_pwdata = d;
        apb_bus.apb_psel = 1'b1; apb_bus.apb_penable = 1'b0;
        @(posedge apb_clk); #1;
        apb_bus.apb_penable = 1'b1;
        core_pop = do_pop; core_ch = pch;
        waits = 0; got = 1'b0;
        while (!got && waits < 8) begin
            @(posedge apb_clk); #1;
            core_pop = 1'b0;
            waits++;
            got = apb_bus.apb_ready;
        end
        check_eq("wait_states", 128'(waits), 128'd1);
        r = apb_bus.apb_prdata; pv = core_valid; pd = core_data; sc = start_core;
`ifdef SEIZURE_REGBANK_PSLVERR_EN
        last_err = apb_bus.apb_pslverr;
`else
        last_err = 1'b0;
`endif
        apb_bus.apb_psel = 1'b0; apb_bus.apb_penable = 1'b0; apb_bus.apb_pwrite = 1'b0;
        @(posedge apb_clk); #1;
        check_eq("ready_single", 128'(apb_bus.apb_ready), 128'd0);
    endtask

    task automatic apb_wr(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] r; logic pv; logic [SAMPLE_W-1:0] pd; logic sc;
        apb_xfer(a, 1'b1, d, 1'b0, 2'd0, r, pv, pd, sc);
    endtask

    task automatic apb_rd(input logic [9:0] a, output logic [31:0] r);
        logic pv; logic [SAMPLE_W-1:0] pd; logic sc;
        apb_xfer(a, 1'b0, 32'h0, 1'b0, 2'd0, r, pv, pd, sc);
    endtask

    task automatic sample_wr(input logic [31:0] d);
        apb_wr(A_SAMPLE, d);
        m_push(m_ch, d[SAMPLE_W-1:0]);
    endtask

    task automatic chsel_wr(input logic [31:0] d);
        apb_wr(A_CHSEL, d);
        if (d < NUM_CH) m_ch = int'(d);
    endtask

    // Pop via the core port and compare against the model.
    task automatic pop_chk(input logic [1:0] ch, input string tag);
        logic ev; logic [SAMPLE_W-1:0] ed;
        @(posedge apb_clk); #1;
        core_pop = 1'b1; core_ch = ch;
        @(posedge apb_clk); #1;
        core_pop = 1'b0;
        m_pop(int'(ch), ev, ed);
        check_eq({tag, "_valid"}, 128'(core_valid), 128'(ev));
        check_eq({tag, "_data"}, 128'(core_data), 128'(ed));
    endtask

    task automatic status_chk(input string tag);
        logic [31:0] r;
        apb_rd(A_STATUS, r);
        check_eq(tag, 128'(r), 128'(exp_status()));
    endtask

    task automatic lut_commit_chk(input string tag);
        int n;
        logic [LUT_W-1:0] ed;
        logic [10:0] ea;
        ea = m_laddr;
        ed = m_stage[LUT_W-1:0];
        apb_wr(A_COMMIT, 32'h1);
        m_laddr = m_laddr + 11'd1;
        n = 0;
        while (!lut_wr_en && n < 4) begin
            @(posedge apb_clk); #1;
            n++;
        end
        check_eq({tag, "_en"}, 128'(lut_wr_en), 128'd1);
        check_eq({tag, "_addr"}, 128'(lut_wr_addr), 128'(ea));
        check_eq({tag, "_data"}, 128'(lut_wr_data), 128'(ed));
        @(posedge apb_clk); #1;
        check_eq({tag, "_en_pulse"}, 128'(lut_wr_en), 128'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic pv, sc, ev;
        logic [SAMPLE_W-1:0] pd, ed;
        logic [95:0] tmp;
        logic [31:0] d;
        int op;
        logic [1:0] pch;

        reset_n = 1'b0; core_pop = 1'b0; core_ch = 2'd0; core_busy = 1'b0;
        apb_bus.apb_addr = 10'h0; apb_bus.apb_psel = 1'b0; apb_bus.apb_penable = 1'b0;
        apb_bus.apb_pwrite = 1'b0; apb_bus.apb_pwdata = 32'h0;
        m_flush(); m_ch = 0; m_laddr = 11'h0; m_stage = 96'h0;
        repeat (3) @(posedge apb_clk);
        #1 reset_n = 1'b1;
        @(posedge apb_clk); #1;

        // Reset state of every output
        check_eq("rst_apb", {95'h0, apb_bus.apb_ready, apb_bus.apb_prdata}, 128'h0);
        check_eq("rst_core", {108'h0, start_core, core_valid, core_data}, 128'h0);
        check_eq("rst_lut", {44'h0, lut_wr_en, lut_wr_addr, lut_wr_data}, 128'h0);

        // Start pulse: exactly one cycle, other outputs quiet
        apb_xfer(A_CTRL, 1'b1, 32'h1, 1'b0, 2'd0, r, pv, pd, sc);
        check_eq("start_pulse", 128'(sc), 128'd1);
        check_eq("start_others", {lut_wr_en, core_valid, core_data}, 128'h0);
        check_eq("start_drop", 128'(start_core), 128'd0);
        apb_rd(A_CTRL, r);
        check_eq("ctrl_read", 128'(r), 128'h0);

        // Channel 2: two pushes, head read, pops in order, then underflow
        chsel_wr(32'd2);
        sample_wr(32'h3FFFF);
        sample_wr(32'h00001);
        apb_rd(A_SAMPLE, r);
        check_eq("sample_head", 128'(r), 128'h3FFFF);
        pop_chk(2'd2, "ch2_pop1");
        pop_chk(2'd2, "ch2_pop2");
        pop_chk(2'd2, "ch2_pop3");
        apb_rd(A_STATUS, r);
        check_eq("udf_bit", 128'(r[2]), 128'd1);
        check_eq("udf_status", 128'(r), 128'(exp_status()));

        apb_wr(A_CTRL, 32'h2); m_flush();
        status_chk("flush_status");

        // Overflow on ch0 with 17 pushes, then drain in order
        chsel_wr(32'd0);
        for (int i = 0; i < 17; i++) sample_wr(32'h100 + 32'(i * 7));
        apb_rd(A_STATUS, r);
        check_eq("full_bit16", 128'(r[16]), 128'd1);
        check_eq("ovf_bit1", 128'(r[1]), 128'd1);
        for (int i = 0; i < 16; i++) pop_chk(2'd0, "drain");

        // Full FIFO: same-cycle push and pop both succeed
        apb_wr(A_CTRL, 32'h2); m_flush();
        for (int i = 0; i < 16; i++) sample_wr(32'h2000 + 32'(i));
        apb_xfer(A_SAMPLE, 1'b1, 32'h2AAAA, 1'b1, 2'd0, r, pv, pd, sc);
        m_pop(0, ev, ed); m_push(0, 18'h2AAAA);
        check_eq("pp_valid", 128'(pv), 128'(ev));
        check_eq("pp_data", 128'(pd), 128'(ed));
        apb_rd(A_STATUS, r);
        check_eq("pp_no_ovf", 128'(r[1]), 128'd0);
        check_eq("pp_full", 128'(r), 128'(exp_status()));

        // Invalid CH_SEL is ignored
        chsel_wr(32'd2);
        chsel_wr(32'd7);
        apb_rd(A_CHSEL, r);
        check_eq("chsel_keep", 128'(r), 128'd2);

        // Flush coincident with pop wins
        sample_wr(32'h155);
        apb_xfer(A_CTRL, 1'b1, 32'h2, 1'b1, 2'd2, r, pv, pd, sc);
        m_flush();
        check_eq("flush_pop_valid", 128'(pv), 128'd0);
        status_chk("flush_pop_status");
        pop_chk(2'd2, "flush_pop_empty");
        apb_wr(A_CTRL, 32'h2); m_flush();

        // LUT staging, truncated top beat, commit at the wrap address
        apb_wr(A_LADDR, 32'h7FF); m_laddr = 11'h7FF;
        apb_wr(A_BEAT0, 32'hAABBCCDD); m_stage[31:0] = 32'hAABBCCDD;
        apb_wr(A_BEAT0 + 10'h4, 32'h11223344); m_stage[63:32] = 32'h11223344;
        apb_wr(A_BEAT0 + 10'h8, 32'hFFFFFF55); m_stage[95:64] = 32'hFFFFFF55;
        m_stage[95:72] = 24'h0;
        apb_rd(A_BEAT0 + 10'h8, r);
        check_eq("beat2_trunc", 128'(r), 128'h55);
        lut_commit_chk("lut_7ff");
        check_eq("lut_ref_data", 128'(m_stage[71:0]), 128'h55_11223344_AABBCCDD);
        apb_rd(A_LADDR, r);
        check_eq("laddr_wrap", 128'(r), 128'h0);
        lut_commit_chk("lut_000");
        apb_rd(A_LADDR, r);
        check_eq("laddr_inc", 128'(r), 128'h1);

        // Unmapped read
        apb_rd(10'h3FC, r);
        check_eq("unmapped_rd", 128'(r), 128'h0);
`ifdef SEIZURE_REGBANK_PSLVERR_EN
        check_eq("unmapped_err", 128'(last_err), 128'd1);
`endif
        apb_wr(10'h3FC, 32'hFFFFFFFF);

        // Random traffic against the model
        for (int it = 0; it < 250; it++) begin
            op = int'($urandom_range(0, 11));
            core_busy = 1'($urandom_range(0, 1));
            pch = 2'($urandom_range(0, 3));
            d = $urandom;
            case (op)
                0: chsel_wr(32'($urandom_range(0, 5)));
                1, 2, 3: sample_wr(d);
                4, 5: pop_chk(pch, "rnd_pop");
                6: begin
                    apb_xfer(A_SAMPLE, 1'b1, d, 1'b1, pch, r, pv, pd, sc);
                    m_pop(int'(pch), ev, ed);
                    m_push(m_ch, d[SAMPLE_W-1:0]);
                    check_eq("rnd_pp_valid", 128'(pv), 128'(ev));
                    check_eq("rnd_pp_data", 128'(pd), 128'(ed));
                end
                7: status_chk("rnd_status");
                8: begin
                    apb_rd(A_SAMPLE, r);
                    if (fq[m_ch].size() > 0)
                        check_eq("rnd_sample", 128'(r), 128'(fq[m_ch][0]));
                end
                9: begin
                    apb_rd(A_CHSEL, r);
                    check_eq("rnd_chsel", 128'(r), 128'(m_ch));
                end
                10: begin
                    op = int'($urandom_range(0, 2));
                    apb_wr(A_BEAT0 + 10'(op * 4), d);
                    m_stage[op * 32 +: 32] = d;
                    m_stage[95:72] = 24'h0;
                    tmp = m_stage;
                    apb_rd(A_BEAT0 + 10'(op * 4), r);
                    check_eq("rnd_beat", 128'(r), 128'(tmp[op * 32 +: 32]));
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        apb_wr(A_CTRL, 32'h2);
                        m_flush();
                    end else begin
                        pop_chk(pch, "rnd_pop2");
                    end
                end
            endcase
        end
        core_busy = 1'b1;
        status_chk("final_status");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
